// File: rtl/timer_pkg.sv
// Shared game-timing definitions: FSM state encoding for down-counting timers
// and a helper that sizes prescaler counters.
package timer_pkg;

    // Timer FSM states; encoding is shared with other game-timing blocks.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } timer_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_PRESCALE = 4;

    // Bits needed for a prescaler counting 0..p-1; never less than one bit.
    function automatic int presc_bits(input int p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: emits a one-cycle tick every PRESCALE enabled clocks.
// Ports: clk, reset (async, active-high), en (advance), clr (restart phase),
//        tick (high on the enabled cycle that completes a prescale period).
module tick_gen
    import timer_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = presc_bits(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;

    // Tick is qualified by en so a frozen prescaler never fires.
    assign tick = en && (presc == LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (clr) begin
            presc <= '0;
        end else if (en) begin
            if (tick) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

endmodule

// File: rtl/down_timer.sv
// Loadable, pausable down-counter with optional auto-reload and a one-cycle
// done pulse on each terminal tick.
// Ports: clk, reset (async, active-high), start, load_val[WIDTH], auto_reload,
//        pause, abort -> count[WIDTH], busy (RUN|HOLD), done (registered pulse).
module down_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    timer_state_t     state;
    logic [WIDTH-1:0] reload_reg;
    logic             tick;
    logic             active;

    assign busy = (state == S_RUN) || (state == S_HOLD);

    // The prescaler advances on every un-paused busy edge, including the
    // edge that leaves HOLD, so a pause of N cycles delays by exactly N.
    assign active = busy && !pause;

    tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (active),
        .clr  (start | abort),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            count      <= '0;
            reload_reg <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                count <= '0;
            end else if (start) begin
                // Retrigger discards any coincident terminal tick.
                if (load_val != '0) begin
                    state      <= S_RUN;
                    count      <= load_val;
                    reload_reg <= load_val;
                end else begin
                    // Zero-length timer: finishes immediately.
                    state <= S_IDLE;
                    count <= '0;
                    done  <= 1'b1;
                end
            end else begin
                unique case (state)
                    S_IDLE: begin
                        state <= S_IDLE;
                    end
                    S_RUN, S_HOLD: begin
                        if (pause) begin
                            state <= S_HOLD;
                        end else begin
                            state <= S_RUN;
                            if (tick) begin
                                if (count == WIDTH'(1)) begin
                                    done <= 1'b1;
                                    if (auto_reload) begin
                                        count <= reload_reg;
                                    end else begin
                                        count <= '0;
                                        state <= S_IDLE;
                                    end
                                end else if (count != '0) begin
                                    count <= count - WIDTH'(1);
                                end
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        count <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: a default instance (WIDTH=8, PRESCALE=4)
// and a fast one (WIDTH=4, PRESCALE=1) driven by the same stimulus.
module tb_down_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] load_val;
    logic [3:0] load4;
    logic       auto_reload;
    logic       pause;
    logic       abort;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [3:0] count2;
    logic       busy2;
    logic       done2;

    always #5 clk = ~clk;

    down_timer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_val   (load_val),
        .auto_reload(auto_reload),
        .pause      (pause),
        .abort      (abort),
        .count      (count),
        .busy       (busy),
        .done       (done)
    );

    down_timer #(
        .WIDTH   (4),
        .PRESCALE(1)
    ) dut2 (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .load_val   (load4),
        .auto_reload(auto_reload),
        .pause      (pause),
        .abort      (abort),
        .count      (count2),
        .busy       (busy2),
        .done       (done2)
    );

    // Reference model: remaining ticks plus un-paused running cycles
    // since the last load; a tick falls on every p-th such cycle.
    typedef struct {
        bit run;
        int n;
        int cnt;
        int el;
        bit done;
    } mdl_t;

    typedef struct {
        int cnt;
        bit busy;
        bit done;
    } exp_t;

    mdl_t m1, m2;
    exp_t q1[$];
    exp_t q2[$];
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;

    function automatic mdl_t mstep(mdl_t m, bit st, int ld, bit ar,
                                   bit pz, bit ab, int p);
        m.done = 1'b0;
        if (ab) begin
            m.run = 1'b0;
            m.cnt = 0;
        end else if (st) begin
            if (ld != 0) begin
                m.run = 1'b1;
                m.n   = ld;
                m.cnt = ld;
                m.el  = 0;
            end else begin
                m.run  = 1'b0;
                m.cnt  = 0;
                m.done = 1'b1;
            end
        end else if (m.run && !pz) begin
            m.el++;
            if (m.el % p == 0) begin
                m.cnt--;
                if (m.cnt == 0) begin
                    m.done = 1'b1;
                    if (ar) m.cnt = m.n;
                    else m.run = 1'b0;
                end
            end
        end
        return m;
    endfunction

    task automatic chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, req);
        end
    endtask

    task automatic step(bit st, int ld, bit ar, bit pz, bit ab);
        exp_t e;
        int   l8, l4;
        l8 = ld & 255;
        l4 = ld & 15;
        @(negedge clk);
        start       = st;
        load_val    = 8'(l8);
        load4       = 4'(l4);
        auto_reload = ar;
        pause       = pz;
        abort       = ab;
        m1 = mstep(m1, st, l8, ar, pz, ab, 4);
        m2 = mstep(m2, st, l4, ar, pz, ab, 1);
        e.cnt = m1.cnt; e.busy = m1.run; e.done = m1.done;
        q1.push_back(e);
        e.cnt = m2.cnt; e.busy = m2.run; e.done = m2.done;
        q2.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic idle(int n, bit ar);
        repeat (n) step(1'b0, 0, ar, 1'b0, 1'b0);
    endtask

    // Monitor: after every active edge compare both DUTs with the queues.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (mon_en) begin
            if (q1.size() == 0 || q2.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty at %0t: got 0 entries want 1", $time);
            end else begin
                e = q1.pop_front();
                chk("count", int'(count), e.cnt);
                chk("busy", int'(busy), int'(e.busy));
                chk("done", int'(done), int'(e.done));
                e = q2.pop_front();
                chk("count_p1", int'(count2), e.cnt);
                chk("busy_p1", int'(busy2), int'(e.busy));
                chk("done_p1", int'(done2), int'(e.done));
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        load_val = '0;
        load4 = '0;
        auto_reload = 1'b0;
        pause = 1'b0;
        abort = 1'b0;
        m1 = '{1'b0, 0, 0, 0, 1'b0};
        m2 = m1;
        repeat (2) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count_p1", int'(count2), 0);
        reset = 1'b0;

        // Asynchronous reset in the middle of a count of 5.
        @(negedge clk);
        start = 1'b1;
        load_val = 8'd5;
        load4 = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_count", int'(count), 5);
        chk("pre_rst_busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_count", int'(count), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_done", int'(done), 0);
        chk("async_busy_p1", int'(busy2), 0);
        @(negedge clk);
        reset = 1'b0;

        // Basic countdown of 3.
        step(1'b1, 3, 1'b0, 1'b0, 1'b0);
        idle(15, 1'b0);
        // Pause for five cycles mid-count.
        step(1'b1, 2, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        repeat (5) step(1'b0, 0, 1'b0, 1'b1, 1'b0);
        idle(10, 1'b0);
        // Auto-reload, then drop it.
        step(1'b1, 2, 1'b1, 1'b0, 1'b0);
        idle(30, 1'b1);
        idle(12, 1'b0);
        // Zero-length timer.
        step(1'b1, 0, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        // Retrigger on the terminal-tick edge.
        step(1'b1, 1, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);
        step(1'b1, 6, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        // Abort together with pause and start.
        step(1'b1, 4, 1'b0, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b1, 7, 1'b0, 1'b1, 1'b1);
        idle(3, 1'b0);
        // Full-range load for the fast instance.
        step(1'b1, 15, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b0);

        // Randomized traffic.
        begin
            bit ar;
            ar = 1'b0;
            for (int i = 0; i < 1500; i++) begin
                bit st, pz, ab;
                int ld;
                if ($urandom_range(0, 39) == 0) ar = ~ar;
                st = ($urandom_range(0, 19) == 0);
                pz = ($urandom_range(0, 7) == 0);
                ab = ($urandom_range(0, 59) == 0);
                if ($urandom_range(0, 3) == 0) ld = int'($urandom_range(0, 255));
                else ld = int'($urandom_range(0, 6));
                step(st, ld, ar, pz, ab);
            end
        end
        idle(10, 1'b0);

        @(posedge clk);
        #2;
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
